// File: rtl/magnitude_window_ctrl_if.sv
// Result channel from the window controller to the display path:
// amplitude/offset words qualified by a valid/ready handshake.
interface magnitude_window_ctrl_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] res_amp;
  logic [DATA_W-1:0] res_offset;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output res_amp,
    output res_offset,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_amp,
    input  res_offset,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/magnitude_window_ctrl.sv
// Measurement-window sequencer for the ADC min/max magnitude tracker: clear, settle,
// track for a programmed sample count, then capture the result into held registers.
module magnitude_window_ctrl #(
  parameter int DATA_W         = 12,
  parameter int WIN_W          = 26,
  parameter int SETTLE_SAMPLES = 4,
  parameter int DP_LAT         = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic [WIN_W-1:0]       i_win_len,
  input  logic                   i_sample_valid,
  input  logic [DATA_W-1:0]      i_meas_amp,
  input  logic [DATA_W-1:0]      i_meas_offset,
  output logic                   o_meas_clr,
  output logic                   o_meas_en,
  input  logic                   i_ovr_clr,
  output logic                   o_overrun,
  output logic                   o_busy,
  magnitude_window_ctrl_if.master res_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  localparam logic [WIN_W-1:0] ONE         = WIN_W'(1);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_SAMPLES - 1);
  localparam logic [WIN_W-1:0] DP_LAST     = WIN_W'(DP_LAT - 1);

  state_t              r_state;
  logic [WIN_W-1:0]    r_cnt;
  logic [WIN_W-1:0]    r_len;
  logic                r_meas_clr;
  logic                r_meas_en;
  logic                r_busy;
  logic [DATA_W-1:0]   r_res_amp;
  logic [DATA_W-1:0]   r_res_offset;
  logic                r_res_valid;
  logic                r_overrun;

  state_t              w_state_nxt;
  logic [WIN_W-1:0]    w_cnt_nxt;
  logic [WIN_W-1:0]    w_len_nxt;
  logic                w_load;

  // Next-state, counter and capture-strobe logic; enable low aborts any active window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_nxt = S_CLEAR;
        else          w_state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_len_nxt   = (i_win_len == '0) ? ONE : i_win_len;
          w_cnt_nxt   = '0;
          w_state_nxt = (SETTLE_SAMPLES == 0) ? S_MEASURE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_sample_valid) begin
          if (r_cnt == SETTLE_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_MEASURE;
          end else begin
            w_cnt_nxt   = r_cnt + ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_MEASURE: begin
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_sample_valid) begin
          if (r_cnt == r_len - ONE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_CAPTURE;
          end else begin
            w_cnt_nxt   = r_cnt + ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_CAPTURE: begin
        // Tracker outputs settle DP_LAT clocks after the last enabled sample.
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DP_LAST) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_CLEAR;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters, registered strobes and the held result / handshake registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_meas_clr   <= 1'b0;
      r_meas_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_res_amp    <= '0;
      r_res_offset <= '0;
      r_res_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_meas_clr <= (w_state_nxt == S_CLEAR);
      r_meas_en  <= (w_state_nxt == S_MEASURE);
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_load) begin
        r_res_amp    <= i_meas_amp;
        r_res_offset <= i_meas_offset;
      end
      if (w_load) begin
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_if.res_ready) begin
        r_res_valid <= 1'b0;
      end
      // A fresh overrun takes priority over a same-cycle clear request.
      if (w_load && r_res_valid && !res_if.res_ready) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_meas_clr        = r_meas_clr;
  assign o_meas_en         = r_meas_en;
  assign o_busy            = r_busy;
  assign o_overrun         = r_overrun;
  assign res_if.res_amp    = r_res_amp;
  assign res_if.res_offset = r_res_offset;
  assign res_if.res_valid  = r_res_valid;

endmodule

// File: tb/tb_magnitude_window_ctrl.sv
// Directed bench for magnitude_window_ctrl: a cycle table for the first window plus
// hand-written sequences for overrun, abort, zero length, load/consume overlap and reset.
module tb_magnitude_window_ctrl;
  localparam int DATA_W = 12;
  localparam int WIN_W  = 26;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              sv;
  logic              ovr_clr;
  logic [WIN_W-1:0]  win_len;
  logic [DATA_W-1:0] amp;
  logic [DATA_W-1:0] off;
  logic              meas_clr;
  logic              meas_en;
  logic              overrun;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic clr;
    logic en;
    logic valid;
    logic busy;
  } vec_t;

  vec_t tbl [12];

  magnitude_window_ctrl_if #(.DATA_W(DATA_W)) rif ();

  magnitude_window_ctrl #(
    .DATA_W(DATA_W), .WIN_W(WIN_W), .SETTLE_SAMPLES(4), .DP_LAT(1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .i_win_len      (win_len),
    .i_sample_valid (sv),
    .i_meas_amp     (amp),
    .i_meas_offset  (off),
    .o_meas_clr     (meas_clr),
    .o_meas_en      (meas_en),
    .i_ovr_clr      (ovr_clr),
    .o_overrun      (overrun),
    .o_busy         (busy),
    .res_if         (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  en_cnt;
    int  pulses;
    bit  got;

    // Expected outputs after each edge of the first window (sample_valid every cycle).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; enable = 1'b0; sv = 1'b0; ovr_clr = 1'b0;
    win_len = 26'd4; amp = 12'h123; off = 12'h456; rif.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_clr",     32'(meas_clr),      32'd0);
    chk("rst_en",      32'(meas_en),       32'd0);
    chk("rst_valid",   32'(rif.res_valid), 32'd0);
    chk("rst_overrun", 32'(overrun),       32'd0);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_amp",     32'(rif.res_amp),   32'd0);
    chk("rst_offset",  32'(rif.res_offset),32'd0);

    // First window, checked cycle by cycle from the table.
    rst = 1'b0; enable = 1'b1; sv = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("t1_clr[%0d]", k + 1),   32'(meas_clr),      32'(tbl[k].clr));
      chk($sformatf("t1_en[%0d]", k + 1),    32'(meas_en),       32'(tbl[k].en));
      chk($sformatf("t1_valid[%0d]", k + 1), 32'(rif.res_valid), 32'(tbl[k].valid));
      chk($sformatf("t1_busy[%0d]", k + 1),  32'(busy),          32'(tbl[k].busy));
      if (k == 10) begin
        chk("t1_amp",     32'(rif.res_amp),    32'h123);
        chk("t1_offset",  32'(rif.res_offset), 32'h456);
        chk("t1_overrun", 32'(overrun),        32'd0);
      end
    end

    // Second back-to-back window without consuming: overrun.
    amp = 12'h0AA; off = 12'h0BB;
    for (int k = 13; k <= 21; k++) tick();
    chk("t2_valid",   32'(rif.res_valid),  32'd1);
    chk("t2_amp",     32'(rif.res_amp),    32'h0AA);
    chk("t2_offset",  32'(rif.res_offset), 32'h0BB);
    chk("t2_overrun", 32'(overrun),        32'd1);
    ovr_clr = 1'b1; enable = 1'b0;
    tick();
    ovr_clr = 1'b0;
    chk("t2_ovr_clr", 32'(overrun),       32'd0);
    chk("t2_busy",    32'(busy),          32'd0);
    chk("t2_hold",    32'(rif.res_valid), 32'd1);
    chk("t2_amp_hold",32'(rif.res_amp),   32'h0AA);

    // Load coincident with consume: stays valid, no overrun.
    enable = 1'b1; amp = 12'h0F0; off = 12'h0F1; win_len = 26'd4;
    repeat (10) tick();
    rif.res_ready = 1'b1;
    tick();
    chk("t5_valid",   32'(rif.res_valid),  32'd1);
    chk("t5_amp",     32'(rif.res_amp),    32'h0F0);
    chk("t5_offset",  32'(rif.res_offset), 32'h0F1);
    chk("t5_overrun", 32'(overrun),        32'd0);
    enable = 1'b0;
    tick();
    rif.res_ready = 1'b0;
    chk("t5_consumed", 32'(rif.res_valid), 32'd0);
    chk("t5_idle",     32'(busy),          32'd0);

    // Abort on the 2nd measure sample of an 8-sample window.
    win_len = 26'd8; amp = 12'h777; enable = 1'b1;
    repeat (7) tick();
    chk("t3_en_before", 32'(meas_en), 32'd1);
    enable = 1'b0;
    tick();
    chk("t3_en",    32'(meas_en),       32'd0);
    chk("t3_busy",  32'(busy),          32'd0);
    chk("t3_valid", 32'(rif.res_valid), 32'd0);
    chk("t3_amp",   32'(rif.res_amp),   32'h0F0);

    // Zero window length behaves as one sample.
    win_len = 26'd0; amp = 12'h321; off = 12'h654; enable = 1'b1; en_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (meas_en) en_cnt++;
    end
    chk("t4_en_cycles", 32'(en_cnt),         32'd1);
    chk("t4_valid",     32'(rif.res_valid),  32'd1);
    chk("t4_amp",       32'(rif.res_amp),    32'h321);
    chk("t4_offset",    32'(rif.res_offset), 32'h654);

    // Reset in SETTLE with sparse samples, then a full restart.
    enable = 1'b0;
    tick();
    enable = 1'b1; win_len = 26'd4; amp = 12'h5A5; off = 12'h1E1;
    for (int i = 0; i < 6; i++) begin
      sv = (i % 3 == 0);
      tick();
    end
    chk("t6_settle_busy", 32'(busy),    32'd1);
    chk("t6_settle_en",   32'(meas_en), 32'd0);
    rst = 1'b1;
    tick();
    chk("t6_rst_busy",   32'(busy),           32'd0);
    chk("t6_rst_clr",    32'(meas_clr),       32'd0);
    chk("t6_rst_valid",  32'(rif.res_valid),  32'd0);
    chk("t6_rst_amp",    32'(rif.res_amp),    32'd0);
    chk("t6_rst_offset", 32'(rif.res_offset), 32'd0);
    rst = 1'b0;
    pulses = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      sv = (i % 3 == 0);
      if (meas_en && sv) pulses++;
      tick();
      if (rif.res_valid) got = 1'b1;
    end
    chk("t6_timeout", 32'(got),            32'd1);
    chk("t6_pulses",  32'(pulses),         32'd4);
    chk("t6_amp",     32'(rif.res_amp),    32'h5A5);
    chk("t6_offset",  32'(rif.res_offset), 32'h1E1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
